e2prom_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one byte-level I2C EEPROM driver (start / ctrl_w0_r1 / addr / data_write in, flag_done / data_read back) between NUM_REQ requesters. It latches one requester's command, holds `start` until the driver's `flag_done` rises, returns read data with a one-cycle acknowledge, and enforces a post-transaction idle gap so EEPROM writes complete before the next access. It sits between the application clients and the I2C driver.

---
 rtl/e2prom_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_e2prom_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/e2prom_arbiter.sv
// ---------------------------------------------------------------------------
// e2prom_arbiter
//
// Purpose: shares one byte-level I2C EEPROM driver between NUM_REQ clients.
// A round-robin pick in IDLE latches one client's command and presents it to
// the driver. `start` is held until a fresh rising edge of `flag_done` is seen,
// or until the BUSY timeout expires. The served client then gets a one-cycle
// `ack`, with `rdata`/`err` valid in that cycle. A post-transaction idle gap
// then gives an EEPROM write time to finish before the next grant.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   req, req_w0_r1        per-client request level and op (0 write, 1 read)
//   req_addr, req_wdata   packed per-client address (16b) and write data (8b)
//   ack, err, rdata       one-hot completion pulse, timeout flag, read byte
//   busy                  high while a transaction or its gap is in progress
//   start, ctrl_w0_r1,
//   addr, data_write      command towards the I2C driver
//   flag_done, data_read  completion level and read byte from the driver
// ---------------------------------------------------------------------------
module e2prom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WR_GAP  = 5000,
    parameter int RD_GAP  = 250,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_w0_r1,
    input  logic [16*NUM_REQ-1:0]  req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic [7:0]             rdata,
    output logic                   busy,
    output logic                   start,
    output logic                   ctrl_w0_r1,
    output logic [15:0]            addr,
    output logic [7:0]             data_write,
    input  logic                   flag_done,
    input  logic [7:0]             data_read
);

    localparam int          IDXW    = $clog2(NUM_REQ);
    localparam logic [15:0] WR_LOAD = 16'(WR_GAP - 1);
    localparam logic [15:0] RD_LOAD = 16'(RD_GAP - 1);
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     last_q, last_d;
    logic                flag_done_q;
    logic [15:0]         gap_q, gap_d;
    logic [23:0]         tmo_q, tmo_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                ctrl_q, ctrl_d;
    logic [15:0]         addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;

    logic                grantValid;
    logic [IDXW-1:0]     grantIdx;
    logic                doneRise;

    // A completion needs a fresh edge of flag_done; a level that was already
    // high when BUSY was entered is ignored because flag_done_q tracks it.
    assign doneRise = flag_done & ~flag_done_q;

    // Round-robin search starting just after the last winner, wrapping.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grantValid && req[(int'(last_q) + k) % NUM_REQ]) begin
                grantValid = 1'b1;
                grantIdx   = IDXW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and datapath. The driver command only changes on a grant;
    // the last winner doubles as the index of the client being served.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        ack_d   = '0;
        err_d   = err_q;
        rdata_d = rdata_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    state_d = BUSY;
                    last_d  = grantIdx;
                    ctrl_d  = req_w0_r1[grantIdx];
                    addr_d  = req_addr[16*grantIdx +: 16];
                    wdata_d = req_wdata[8*grantIdx +: 8];
                    tmo_d   = '0;
                end
            end
            BUSY: begin
                if (doneRise) begin
                    state_d        = GAP;
                    ack_d[last_q]  = 1'b1;
                    err_d          = 1'b0;
                    if (ctrl_q) begin
                        rdata_d = data_read;
                    end
                    gap_d = ctrl_q ? RD_LOAD : WR_LOAD;
                end else if (tmo_q == TO_LAST) begin
                    state_d       = GAP;
                    ack_d[last_q] = 1'b1;
                    err_d         = 1'b1;
                    gap_d         = WR_LOAD;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            last_q      <= IDXW'(NUM_REQ - 1);
            flag_done_q <= 1'b0;
            gap_q       <= '0;
            tmo_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ctrl_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            flag_done_q <= flag_done;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign start      = (state_q == BUSY);
    assign busy       = (state_q != IDLE);
    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign ctrl_w0_r1 = ctrl_q;
    assign addr       = addr_q;
    assign data_write = wdata_q;

endmodule

// File: tb/tb_e2prom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_e2prom_arbiter
//
// Self-checking bench for e2prom_arbiter with two clients, short gaps and a
// short timeout. Client commands are random. The expected winner, read data
// and gap length come from a small model of the arbitration rules held here.
// ---------------------------------------------------------------------------
module tb_e2prom_arbiter;

    localparam int TNR = 2;
    localparam int TWR = 20;
    localparam int TRD = 8;
    localparam int TTO = 100;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [TNR-1:0]    reqMask;
    logic              opArr   [TNR];
    logic [15:0]       addrArr [TNR];
    logic [7:0]        wdArr   [TNR];
    logic [TNR-1:0]    req_w0_r1;
    logic [16*TNR-1:0] req_addr;
    logic [8*TNR-1:0]  req_wdata;
    logic [TNR-1:0]    ack;
    logic              err;
    logic [7:0]        rdata;
    logic              busy;
    logic              start;
    logic              ctrl_w0_r1;
    logic [15:0]       addr;
    logic [7:0]        data_write;
    logic              flag_done;
    logic [7:0]        data_read;

    int                testCount = 0;
    int                failCount = 0;
    int                lastW;
    logic [7:0]        modelRdata;

    assign req_w0_r1 = {opArr[1], opArr[0]};
    assign req_addr  = {addrArr[1], addrArr[0]};
    assign req_wdata = {wdArr[1], wdArr[0]};

    always #5 sys_clk = ~sys_clk;

    e2prom_arbiter #(
        .NUM_REQ (TNR),
        .WR_GAP  (TWR),
        .RD_GAP  (TRD),
        .TIMEOUT (TTO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req        (reqMask),
        .req_w0_r1  (req_w0_r1),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .start      (start),
        .ctrl_w0_r1 (ctrl_w0_r1),
        .addr       (addr),
        .data_write (data_write),
        .flag_done  (flag_done),
        .data_read  (data_read)
    );

    // One comparison: counted, and reported with tag and values on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference arbitration: first requesting client after the last winner.
    function automatic int pickWinner(input logic [TNR-1:0] mask, input int last);
        for (int k = 1; k <= TNR; k++) begin
            if (mask[(last + k) % TNR]) return (last + k) % TNR;
        end
        return -1;
    endfunction

    task automatic randomizeCmd(input int i);
        opArr[i]   = 1'($urandom_range(0, 1));
        addrArr[i] = 16'($urandom);
        wdArr[i]   = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [TNR-1:0] mask);
        reqMask = mask;
    endtask

    // Serves one transaction end to end: grant, driver completion (normal,
    // stale-level or timeout), ack pulse, then the length of the idle gap.
    task automatic runTxn(input bit staleDone, input bit doTimeout, input bit dropReq);
        int         cnt;
        int         w;
        int         g;
        int         expGap;
        bit         isRd;
        logic [7:0] rd;
        cnt = 0;
        do begin
            @(negedge sys_clk);
            cnt++;
        end while (start !== 1'b1 && cnt < 50);
        checkOutput("grant_start", start, 1);
        w = pickWinner(reqMask, lastW);
        if (w < 0) w = 0;
        lastW = w;
        isRd  = opArr[w];
        checkOutput("grant_busy", busy, 1);
        checkOutput("grant_op", ctrl_w0_r1, opArr[w]);
        checkOutput("grant_addr", addr, addrArr[w]);
        checkOutput("grant_wdata", data_write, wdArr[w]);
        checkOutput("grant_noack", ack, 0);
        if (dropReq) applyStimulus('0);
        if (doTimeout) begin
            cnt = 1;
            while (cnt < TTO + 20) begin
                @(negedge sys_clk);
                if (start !== 1'b1) break;
                cnt++;
            end
            checkOutput("timeout_len", cnt, TTO);
            checkOutput("timeout_ack", ack, 32'(1 << w));
            checkOutput("timeout_err", err, 1);
            checkOutput("timeout_rdata", rdata, modelRdata);
            expGap = TWR;
        end else begin
            if (staleDone) begin
                repeat (3) begin
                    @(negedge sys_clk);
                    checkOutput("stale_noack", ack, 0);
                    checkOutput("stale_start", start, 1);
                end
                flag_done = 1'b0;
                @(negedge sys_clk);
            end
            repeat ($urandom_range(0, 4)) @(negedge sys_clk);
            rd        = 8'($urandom);
            data_read = rd;
            flag_done = 1'b1;
            @(negedge sys_clk);
            if (isRd) modelRdata = rd;
            checkOutput("done_start", start, 0);
            checkOutput("done_ack", ack, 32'(1 << w));
            checkOutput("done_err", err, 0);
            checkOutput("done_rdata", rdata, modelRdata);
            flag_done = 1'b0;
            data_read = 8'($urandom);
            expGap    = isRd ? TRD : TWR;
        end
        @(negedge sys_clk);
        checkOutput("ack_pulse", ack, 0);
        randomizeCmd(w);
        g = 1;
        while (busy === 1'b1 && g < TWR + 20) begin
            @(negedge sys_clk);
            g++;
        end
        checkOutput("gap_len", g, expGap);
    endtask

    // Directed sequence with randomized commands and driver timing.
    initial begin
        int cnt;
        sys_rst    = 1'b1;
        flag_done  = 1'b0;
        data_read  = 8'h00;
        lastW      = TNR - 1;
        modelRdata = 8'h00;
        for (int i = 0; i < TNR; i++) randomizeCmd(i);
        applyStimulus('0);
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_ctrl", ctrl_w0_r1, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_wdata", data_write, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single write from client 0.
        opArr[0] = 1'b0; addrArr[0] = 16'h0005; wdArr[0] = 8'hA5;
        applyStimulus(2'b01);
        runTxn(1'b0, 1'b0, 1'b0);
        applyStimulus('0);
        @(negedge sys_clk);

        // Single read from client 1, dropping its request mid-transaction.
        opArr[1] = 1'b1; addrArr[1] = 16'h000C;
        applyStimulus(2'b10);
        runTxn(1'b0, 1'b0, 1'b1);
        @(negedge sys_clk);

        // Fairness with both clients requesting continuously.
        applyStimulus(2'b11);
        repeat (6) runTxn(1'b0, 1'b0, 1'b0);
        applyStimulus('0);
        @(negedge sys_clk);

        // Stale flag_done level across the grant.
        flag_done = 1'b1;
        repeat (2) @(negedge sys_clk);
        checkOutput("idle_flag_noack", ack, 0);
        applyStimulus(2'b01);
        runTxn(1'b1, 1'b0, 1'b0);
        applyStimulus('0);
        @(negedge sys_clk);

        // Driver never answers.
        applyStimulus(2'b10);
        runTxn(1'b0, 1'b1, 1'b0);
        applyStimulus('0);
        @(negedge sys_clk);

        // Reset while BUSY.
        applyStimulus(2'b11);
        cnt = 0;
        do begin
            @(negedge sys_clk);
            cnt++;
        end while (start !== 1'b1 && cnt < 50);
        checkOutput("pre_rst_start", start, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checkOutput("midrst_start", start, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ack", ack, 0);
        @(negedge sys_clk);
        checkOutput("midrst_ack2", ack, 0);
        checkOutput("midrst_rdata", rdata, 0);
        sys_rst    = 1'b0;
        lastW      = TNR - 1;
        modelRdata = 8'h00;
        runTxn(1'b0, 1'b0, 1'b0);

        // Random request patterns.
        repeat (8) begin
            applyStimulus(2'($urandom_range(1, 3)));
            runTxn(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        applyStimulus('0);
        repeat (2) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
